pq_sort_host: RTL
=================

PQ_SORT_HOST -- requirements
Module: pq_sort_host

Interface
REQ-001 Parameter MAX_BATCH, default PQ_CAPACITY, maximum entries per batch (1..PQ_CAPACITY).
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 s_kv  input  kv_t  input key-value pair.
REQ-005 s_valid  input  1  s_kv valid.
REQ-006 s_last  input  1  final element of batch.
REQ-007 s_ready  output  1  host accepts s_kv this cycle.
REQ-008 m_kv  output  kv_t  sorted output pair (ascending key).
REQ-009 m_valid / m_ready  output / input  1 each  output handshake.
REQ-010 m_last  output  1  m_kv is final element of batch.
REQ-011 pq_kvi  output  kv_t  to queue, driven from s_kv.
REQ-012 pq_enq / pq_deq  output  1 each  queue commands.
REQ-013 pq_kvo  input  kv_t  queue head (minimum key).
REQ-014 pq_full / pq_empty / pq_busy  input  1 each  queue status.
REQ-015 err_key / ovf  output  1 each  sticky error flags.

Function
REQ-016 States FILL, DRAIN; reset state FILL.
REQ-017 FILL: s_ready = !pq_busy && !pq_full && cnt<MAX_BATCH; a transfer occurs when s_valid && s_ready.
REQ-018 Transfer with s_kv.key != KEYINF: pq_enq=1 same cycle (combinational), pq_kvi=s_kv, cnt += 1.
REQ-019 Transfer with s_kv.key == KEYINF: not enqueued, cnt unchanged, err_key set.
REQ-020 Transfer with s_last=1: next state DRAIN.
REQ-021 cnt reaching MAX_BATCH without s_last: next state DRAIN, ovf set; batch truncated, later inputs belong to next batch.
REQ-022 pq_enq and pq_deq are never asserted together; neither is asserted while pq_busy=1.
REQ-023 DRAIN: when !pq_busy && !pq_empty && cnt>0 && output register empty or being emptied this cycle, pq_deq=1 and pq_kvo is loaded into output register; cnt -= 1.
REQ-024 m_valid rises the cycle after the pq_deq cycle; m_kv, m_last held stable while m_valid && !m_ready.
REQ-025 m_last=1 on the element loaded when cnt was 1.
REQ-026 Throughput is one element per 2 cycles, limited by pq_busy.
REQ-027 DRAIN -> FILL when cnt==0 and output register empty or emptied this cycle.
REQ-028 Entering DRAIN with cnt==0 (KEYINF-only batch) returns to FILL next cycle with no output.
REQ-029 cnt width is $clog2(MAX_BATCH+1).

Reset
REQ-030 rst=1: state FILL, cnt 0, m_valid 0, m_last 0, pq_enq 0, pq_deq 0, err_key 0, ovf 0, stats 0.
REQ-031 Reset mid-batch discards buffered data; the queue is reset by the same rst.

Configuration
REQ-032 PQ_HOST_STATS_EN defined: adds outputs stat_batches (16 b, +1 per DRAIN->FILL) and stat_stalls (16 b, +1 per cycle s_valid && !s_ready), both saturating.
REQ-033 PQ_HOST_STATS_EN undefined: stat ports and counters are absent; all other behaviour is identical.

Structure
REQ-034 kv_t, KEYINF, VAL0, and PQ_CAPACITY come from pq_pkg; enum host_state_t {FILL, DRAIN} is added to pq_pkg.
REQ-035 Single-entry output register is sub-module pq_host_obuf (load, kv, last in; valid/ready handshake out).

Verification
REQ-036 Each scenario runs against ra-style queue PQ_CAPACITY=8 and MAX_BATCH=8.
REQ-037 Keys 5,2,7,1 (last on 1), m_ready=1 -> outputs 1,2,5,7; m_last only on 7; pq_deq spaced at least 2 cycles apart.
REQ-038 8 keys without s_last -> ovf=1 after 8th; DRAIN emits 8 sorted keys; next input accepted in FILL.
REQ-039 Key KEYINF then key 3 with s_last -> err_key=1; single output 3 with m_last=1.
REQ-040 m_ready held 0 for 10 cycles mid-drain -> m_kv stable; no pq_deq while output register full; no loss or duplication.
REQ-041 rst asserted during DRAIN with 3 entries left -> next cycle state FILL, m_valid=0, s_ready=1 once pq_busy=0.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue sort host and its queue.
// Also carries the host FSM state type and a saturating counter helper.
package pq_pkg;

    localparam int KEY_W       = 8;
    localparam int VAL_W       = 8;
    localparam int PQ_CAPACITY = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    // KEYINF marks an empty slot in the queue, so it can never be stored as data.
    localparam logic [KEY_W-1:0] KEYINF = 8'hFF;
    localparam logic [VAL_W-1:0] VAL0   = 8'h00;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } host_state_t;

    function automatic logic is_keyinf(input kv_t kv);
        return (kv.key == KEYINF);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/pq_host_obuf.sv
// Single-entry output register with a valid/ready handshake toward the consumer.
// A new entry may be loaded in the same cycle the current one is taken.
module pq_host_obuf
    import pq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  kv_t  kv_in,
    input  logic last_in,
    input  logic m_ready,
    output kv_t  m_kv,
    output logic m_last,
    output logic m_valid,
    output logic can_load
);

    logic valid_q, valid_d;
    logic last_q,  last_d;
    kv_t  kv_q,    kv_d;

    // Next-state of the holding register: load wins, otherwise drain on handshake.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        kv_d    = kv_q;
        if (load) begin
            valid_d = 1'b1;
            last_d  = last_in;
            kv_d    = kv_in;
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            kv_q    <= kv_t'{key: {KEY_W{1'b0}}, val: VAL0};
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            kv_q    <= kv_d;
        end
    end

    assign m_kv     = kv_q;
    assign m_last   = last_q;
    assign m_valid  = valid_q;
    assign can_load = !valid_q || m_ready;

endmodule

// File: rtl/pq_sort_host.sv
// Batch sorter front-end: fills an external priority queue, then drains it in key order.
// Optional statistics counters are built when PQ_HOST_STATS_EN is defined.
module pq_sort_host
    import pq_pkg::*;
#(
    parameter int MAX_BATCH = PQ_CAPACITY
) (
    input  logic clk,
    input  logic rst,
    input  kv_t  s_kv,
    input  logic s_valid,
    input  logic s_last,
    output logic s_ready,
    output kv_t  m_kv,
    output logic m_valid,
    input  logic m_ready,
    output logic m_last,
    output kv_t  pq_kvi,
    output logic pq_enq,
    output logic pq_deq,
    input  kv_t  pq_kvo,
    input  logic pq_full,
    input  logic pq_empty,
    input  logic pq_busy,
    output logic err_key,
    output logic ovf
`ifdef PQ_HOST_STATS_EN
    ,
    output logic [15:0] stat_batches,
    output logic [15:0] stat_stalls
`endif
);

    localparam int                CNT_W    = $clog2(MAX_BATCH + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_BATCH);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    host_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_key_q, err_key_d;
    logic             ovf_q,     ovf_d;

    logic s_ready_s;
    logic pq_enq_s;
    logic pq_deq_s;
    logic obuf_load_s;
    logic obuf_last_s;
    logic obuf_can_load_s;
    logic batch_done_s;
    logic xfer_s;

    assign xfer_s = s_valid && s_ready_s;

    // Host sequencing: accept and enqueue in FILL, pop the queue minimum in DRAIN.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_key_d    = err_key_q;
        ovf_d        = ovf_q;
        s_ready_s    = 1'b0;
        pq_enq_s     = 1'b0;
        pq_deq_s     = 1'b0;
        obuf_load_s  = 1'b0;
        obuf_last_s  = 1'b0;
        batch_done_s = 1'b0;
        case (state_q)
            FILL: begin
                s_ready_s = !rst && !pq_busy && !pq_full && (cnt_q < MAX_CNT);
                if (xfer_s) begin
                    if (is_keyinf(s_kv)) begin
                        err_key_d = 1'b1;
                    end else begin
                        pq_enq_s = 1'b1;
                        cnt_d    = cnt_q + CNT_ONE;
                    end
                    if (s_last) begin
                        state_d = DRAIN;
                    end else if (!is_keyinf(s_kv) && ((cnt_q + CNT_ONE) == MAX_CNT)) begin
                        // Batch truncated: the next element starts a new batch.
                        state_d = DRAIN;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            DRAIN: begin
                if (!rst && !pq_busy && !pq_empty && (cnt_q != CNT_ZERO) && obuf_can_load_s) begin
                    pq_deq_s    = 1'b1;
                    obuf_load_s = 1'b1;
                    obuf_last_s = (cnt_q == CNT_ONE);
                    cnt_d       = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                if ((cnt_q == CNT_ZERO) && obuf_can_load_s) begin
                    state_d      = FILL;
                    batch_done_s = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Host state, element count and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= CNT_ZERO;
            err_key_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_key_q <= err_key_d;
            ovf_q     <= ovf_d;
        end
    end

    pq_host_obuf u_obuf (
        .clk      (clk),
        .rst      (rst),
        .load     (obuf_load_s),
        .kv_in    (pq_kvo),
        .last_in  (obuf_last_s),
        .m_ready  (m_ready),
        .m_kv     (m_kv),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .can_load (obuf_can_load_s)
    );

    assign s_ready = s_ready_s;
    assign pq_enq  = pq_enq_s;
    assign pq_deq  = pq_deq_s;
    assign pq_kvi  = s_kv;
    assign err_key = err_key_q;
    assign ovf     = ovf_q;

`ifdef PQ_HOST_STATS_EN
    logic [15:0] stat_batches_q, stat_batches_d;
    logic [15:0] stat_stalls_q,  stat_stalls_d;

    // Saturating batch and input-stall counters.
    always_comb begin
        stat_batches_d = stat_batches_q;
        stat_stalls_d  = stat_stalls_q;
        if (batch_done_s) begin
            stat_batches_d = sat_inc16(stat_batches_q);
        end else begin
            stat_batches_d = stat_batches_q;
        end
        if (s_valid && !s_ready_s) begin
            stat_stalls_d = sat_inc16(stat_stalls_q);
        end else begin
            stat_stalls_d = stat_stalls_q;
        end
    end

    // Statistics flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_batches_q <= 16'd0;
            stat_stalls_q  <= 16'd0;
        end else begin
            stat_batches_q <= stat_batches_d;
            stat_stalls_q  <= stat_stalls_d;
        end
    end

    assign stat_batches = stat_batches_q;
    assign stat_stalls  = stat_stalls_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = batch_done_s;
`endif

endmodule
